result_display: RTL

Downstream consumer of the machine's registered 8-bit result (`out`). It converts the unsigned byte to three BCD digits with a sequential double-dabble engine (one bit per cycle), then drives a 4-digit, active-low, common-anode 7-segment display by time-multiplexing the digits. It sits between the machine top and the board display pins; the processor and program ROM are unaffected.

---
 rtl/display_pkg.sv | 34 +++
 rtl/seg7_decode.sv | 34 +++
 rtl/result_display.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the result display block.
//   - state_t     : conversion FSM state encoding
//   - SEG_*       : active-low 7-segment patterns (seg[0]=a .. seg[6]=g)
//   - NUM_DIGITS  : number of scanned digits (ones, tens, hundreds)
//   - bcd_adjust  : double-dabble "add 3 if >= 5" nibble correction
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // A nibble of 5 or more would overflow past 9 after the next shift,
    // so it is pre-corrected by 3 before shifting.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd   in  4  decimal digit to show
//   blank in  1  force all segments off
//   seg   out 7  active-low segments, seg[0]=a .. seg[6]=g
// Non-decimal codes also produce an all-off pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// result_display: shows an unsigned 8-bit result on a 4-digit, active-low,
// common-anode 7-segment display.
// A sequential double-dabble engine (one bit per cycle) turns the byte into
// three BCD digits; a free-running scan counter multiplexes the digits.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  asynchronous active-high reset
//   value in  8  unsigned value to display
//   seg   out 7  segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   an    out 4  digit anodes, active-low; an[0]=ones, an[1]=tens,
//                an[2]=hundreds, an[3] never driven low
//   busy  out 1  high while a conversion is in progress
module result_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Conversion FSM and datapath.
    state_t      state_q, state_d;
    logic [7:0]  captured_q, captured_d;
    logic [19:0] shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [11:0] disp_q, disp_d;
    logic [19:0] adj;

    // Scan logic.
    logic [CNT_W-1:0] refcnt_q, refcnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       sel_bcd;
    logic             sel_blank;
    logic [3:0]       sel_an;
    logic [6:0]       dec_seg;

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        disp_d     = disp_q;

        // Nibble correction happens on the register contents before the shift.
        adj = {bcd_adjust(shreg_q[19:16]),
               bcd_adjust(shreg_q[15:12]),
               bcd_adjust(shreg_q[11:8]),
               shreg_q[7:0]};

        case (state_q)
            ST_IDLE: begin
                // Comparing against the last captured value means a change
                // that arrived mid-conversion is still picked up here.
                if (value != captured_q) begin
                    captured_d = value;
                    shreg_d    = {12'h000, value};
                    bitcnt_d   = 3'd0;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                shreg_d  = adj << 1;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                disp_d  = shreg_q[19:8];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        refcnt_d = refcnt_q + CNT_W'(1);
        digit_d  = digit_q;
        if (refcnt_q == CNT_LAST) begin
            refcnt_d = '0;
            digit_d  = (digit_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : (digit_q + 2'd1);
        end
    end

    // Leading-zero blanking: an inner zero (e.g. the tens of 105) stays lit.
    always_comb begin
        sel_bcd   = disp_q[3:0];
        sel_blank = 1'b0;
        sel_an    = 4'b1110;
        case (digit_q)
            2'd0: begin
                sel_bcd   = disp_q[3:0];
                sel_blank = 1'b0;
                sel_an    = 4'b1110;
            end
            2'd1: begin
                sel_bcd   = disp_q[7:4];
                sel_blank = (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
                sel_an    = 4'b1101;
            end
            2'd2: begin
                sel_bcd   = disp_q[11:8];
                sel_blank = (disp_q[11:8] == 4'd0);
                sel_an    = 4'b1011;
            end
            default: begin
                sel_bcd   = 4'd0;
                sel_blank = 1'b1;
                sel_an    = 4'b1111;
            end
        endcase
    end

    seg7_decode u_dec (
        .bcd   (sel_bcd),
        .blank (sel_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        an_d  = sel_blank ? 4'b1111 : sel_an;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            captured_q <= 8'd0;
            shreg_q    <= 20'd0;
            bitcnt_q   <= 3'd0;
            disp_q     <= 12'd0;
            refcnt_q   <= '0;
            digit_q    <= 2'd0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'b1111;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            disp_q     <= disp_d;
            refcnt_q   <= refcnt_d;
            digit_q    <= digit_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = (state_q != ST_IDLE);

endmodule
